branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- EX-stage branch resolution unit; it is the producer side of the predictor update interface.
- Evaluates the condition and target of each branch/jump leaving ID/EX and compares them with the prediction carried down the pipe.
- Drives the registered update bus (br_update/br/br_address/br_pc) back to the predictor.
- On misprediction, drives a redirect to pc_reg and holds a multi-cycle flush of the front-end stages.

Parameters:
- ADDR_W, 32, instruction address / operand width
- FLUSH_CYCLES, 2, cycles flush_o stays high after a mispredict (≥1)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stall_i  in  1  EX stalled; no input accepted this cycle
- valid_i  in  1  ID/EX holds a branch or jump
- br_type_i  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6 JAL, 7 JALR
- pc_i  in  ADDR_W  pc of the branch instruction
- rs1_i  in  ADDR_W  operand 1
- rs2_i  in  ADDR_W  operand 2
- imm_i  in  ADDR_W  sign-extended immediate
- pred_taken_i  in  1  prediction bit from IF/ID
- pred_target_i  in  ADDR_W  predicted next pc
- br_update_o  out  1  predictor update strobe
- br_o  out  1  resolved taken
- br_address_o  out  ADDR_W  resolved target
- br_pc_o  out  ADDR_W  pc of the resolved instruction
- redirect_o  out  1  pc_reg must load redirect_pc_o
- redirect_pc_o  out  ADDR_W  correct next pc
- flush_o  out  1  clear IF/ID and ID/EX

Behaviour:
- Accept condition: valid_i && !stall_i && state==IDLE. In FLUSH, valid_i is wrong-path and is ignored.
- Resolution, combinational on the inputs:
  - BEQ/BNE: equality test.
  - BLT/BGE: signed compare.
  - BLTU/BGEU: unsigned compare.
  - JAL, JALR: always taken.
- Targets:
  - Branches and JAL: pc_i+imm_i.
  - JALR: (rs1_i+imm_i) with bit0 forced to 0.
  - All adds wrap modulo 2^ADDR_W.
- Mispredict when: taken != pred_taken_i, OR (taken && target != pred_target_i), OR (!taken && pred_taken_i).
- Outputs are registered, with latency 1: an input accepted in cycle N produces its outputs in cycle N+1.
- Update bus:
  - br_update_o is a 1-cycle pulse for every accepted input.
  - br_o, br_address_o and br_pc_o hold their last values when br_update_o is low.
  - br_address_o is the computed target even when not taken.
- Redirect: on mispredict, redirect_o is a 1-cycle pulse with redirect_pc_o = taken ? target : pc_i+4. redirect_o is 0 otherwise.
- FSM IDLE/FLUSH:
  - IDLE→FLUSH on an accepted mispredict, in the same edge that registers the outputs.
  - flush_o is high in exactly FLUSH_CYCLES consecutive cycles, starting with the redirect cycle.
  - A down-counter loads FLUSH_CYCLES-1; FLUSH→IDLE when the counter reaches 0.
  - stall_i does not pause the flush counter.
  - A correctly predicted input stays in IDLE with flush_o=0.
- Back-to-back correct inputs in consecutive cycles each produce their own pulse; there is no bubble.
- Reset values (including reset mid-FLUSH): all outputs 0, state IDLE, counter 0. Reset has priority over any accept.

Optional Feature:
- BR_STATS_EN defined:
  - Adds outputs br_count_o[31:0] and mispredict_count_o[31:0].
  - br_count_o increments per accepted input; mispredict_count_o increments per mispredict.
  - Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines file:
  - Br_type encodings BEQ..JALR.
  - Instruction_Address_size width.
  - FSM state encodings.
- Sub-module branch_cond_unit: combinational compare plus target computation (br_type, pc, rs1, rs2, imm → taken, target).
- The top level holds the registers, FSM and stats.

Test Plan:
- BEQ, rs1=rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 → next cycle br_update_o=1, br_o=1, br_address_o=0x120, br_pc_o=0x100, redirect_o=0, flush_o=0.
- BNE, rs1=rs2, pc=0x200, pred_taken=1, pred_target=0x240 → redirect_o=1, redirect_pc_o=0x204, flush_o high exactly 2 cycles; valid_i applied during those cycles produces no br_update_o.
- JALR, rs1=0x1001, imm=0x4, pred_taken=1, pred_target=0x1004 → target 0x1004, no redirect; then pred_target=0x2000 → redirect to 0x1004.
- BLT rs1=0xFFFFFFFF, rs2=1 → taken; BLTU with the same operands → not taken. Unpredicted in both cases, so only BLT redirects.
- stall_i=1 with valid_i=1 → no pulse. Then assert rst during FLUSH → all outputs 0 next cycle, and a new branch is accepted in the cycle after rst is released.
- BR_STATS_EN defined: 3 branches, 1 mispredicted → br_count_o=3, mispredict_count_o=1. Counters preloaded to 0xFFFFFFFF stay at 0xFFFFFFFF after a further branch.

Source files
------------

// File: rtl/branch_resolver_pkg.sv
// Shared encodings for the EX-stage branch resolver: branch types,
// instruction address width and resolver FSM states.
package branch_resolver_pkg;

  localparam int Instruction_Address_size = 32;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } br_type_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

endpackage

// File: rtl/branch_resolver_cond.sv
// Combinational branch condition evaluation and target computation.
// Target is always produced, even for not-taken branches.
module branch_cond_unit
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W = Instruction_Address_size
) (
  input  logic [2:0]        br_type_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] imm_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o
);

  logic [ADDR_W-1:0] pc_sum;
  logic [ADDR_W-1:0] jalr_sum;
  logic              eq, lt_s, lt_u;

  assign pc_sum   = pc_i + imm_i;
  assign jalr_sum = rs1_i + imm_i;
  assign eq       = (rs1_i == rs2_i);
  assign lt_s     = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u     = (rs1_i < rs2_i);

  always_comb begin
    taken_o  = 1'b0;
    target_o = pc_sum;
    case (br_type_e'(br_type_i))
      BR_BEQ:  taken_o = eq;
      BR_BNE:  taken_o = !eq;
      BR_BLT:  taken_o = lt_s;
      BR_BGE:  taken_o = !lt_s;
      BR_BLTU: taken_o = lt_u;
      BR_BGEU: taken_o = !lt_u;
      BR_JAL:  taken_o = 1'b1;
      BR_JALR: begin
        taken_o  = 1'b1;
        target_o = {jalr_sum[ADDR_W-1:1], 1'b0};
      end
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// EX-stage branch resolver: registered predictor update bus, mispredict
// redirect and multi-cycle front-end flush. BR_STATS_EN adds saturating counters.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ADDR_W       = Instruction_Address_size,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              valid_i,
  input  logic [2:0]        br_type_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic [ADDR_W-1:0] imm_i,
  input  logic              pred_taken_i,
  input  logic [ADDR_W-1:0] pred_target_i,
  output logic              br_update_o,
  output logic              br_o,
  output logic [ADDR_W-1:0] br_address_o,
  output logic [ADDR_W-1:0] br_pc_o,
  output logic              redirect_o,
  output logic [ADDR_W-1:0] redirect_pc_o,
`ifdef BR_STATS_EN
  output logic [31:0]       br_count_o,
  output logic [31:0]       mispredict_count_o,
`endif
  output logic              flush_o
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              accept, mispredict;

  logic              br_update_q, br_q, redirect_q;
  logic [ADDR_W-1:0] br_address_q, br_pc_q, redirect_pc_q;

  branch_cond_unit #(.ADDR_W(ADDR_W)) u_cond (
    .br_type_i (br_type_i),
    .pc_i      (pc_i),
    .rs1_i     (rs1_i),
    .rs2_i     (rs2_i),
    .imm_i     (imm_i),
    .taken_o   (taken),
    .target_o  (target)
  );

  // While flushing, ID/EX holds wrong-path work, so nothing is accepted.
  assign accept     = valid_i && !stall_i && (state_q == ST_IDLE);
  assign mispredict = (taken != pred_taken_i) || (taken && (target != pred_target_i));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The flush counter keeps running under stall_i.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && mispredict) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    flush_o = (state_q == ST_FLUSH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_update_q   <= 1'b0;
      br_q          <= 1'b0;
      br_address_q  <= '0;
      br_pc_q       <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      br_update_q <= accept;
      redirect_q  <= accept && mispredict;
      if (accept) begin
        br_q         <= taken;
        br_address_q <= target;
        br_pc_q      <= pc_i;
        if (mispredict)
          redirect_pc_q <= taken ? target : (pc_i + ADDR_W'(4));
      end
    end
  end

  assign br_update_o   = br_update_q;
  assign br_o          = br_q;
  assign br_address_o  = br_address_q;
  assign br_pc_o       = br_pc_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_q;

`ifdef BR_STATS_EN
  logic [31:0] br_count_q, mis_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else if (accept) begin
      if (br_count_q != '1)                 br_count_q  <= br_count_q + 1'b1;
      if (mispredict && mis_count_q != '1)  mis_count_q <= mis_count_q + 1'b1;
    end
  end

  assign br_count_o         = br_count_q;
  assign mispredict_count_o = mis_count_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized
// traffic against a behavioural model. Define BR_STATS_EN to cover the counters.
module tb_branch_resolver;

  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk, rst, stall, valid, pred_taken;
  logic [2:0]    br_type;
  logic [AW-1:0] pc, rs1, rs2, imm, pred_target;
  logic          br_update, br, redirect, flush;
  logic [AW-1:0] br_address, br_pc, redirect_pc;
`ifdef BR_STATS_EN
  logic [31:0]   br_count, mis_count;
`endif

  int checks = 0;
  int errors = 0;

  // model state
  bit            m_upd, m_br, m_red;
  logic [AW-1:0] m_addr, m_pc, m_rpc;
  int            m_flush_rem;
  longint        m_bc, m_mc;

  branch_resolver #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .stall_i(stall), .valid_i(valid), .br_type_i(br_type),
    .pc_i(pc), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .pred_taken_i(pred_taken), .pred_target_i(pred_target),
    .br_update_o(br_update), .br_o(br), .br_address_o(br_address), .br_pc_o(br_pc),
    .redirect_o(redirect), .redirect_pc_o(redirect_pc),
`ifdef BR_STATS_EN
    .br_count_o(br_count), .mispredict_count_o(mis_count),
`endif
    .flush_o(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_resolve(input logic [2:0] t, input logic [AW-1:0] p,
                                      input logic [AW-1:0] a, input logic [AW-1:0] b,
                                      input logic [AW-1:0] i, output bit tk,
                                      output logic [AW-1:0] tg);
    longint sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (t)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd2: tk = (sa < sb);
      3'd3: tk = (sa >= sb);
      3'd4: tk = ({32'd0, a} < {32'd0, b});
      3'd5: tk = ({32'd0, a} >= {32'd0, b});
      default: tk = 1'b1;
    endcase
    if (t == 3'd7) tg = (a + i) & ~32'd1;
    else           tg = p + i;
  endfunction

  // Advance one clock and update the model from the inputs held across the edge.
  task automatic cycle();
    bit tk, mis, acc;
    logic [AW-1:0] tg;
    ref_resolve(br_type, pc, rs1, rs2, imm, tk, tg);
    acc = valid && !stall && (m_flush_rem == 0);
    mis = (tk != pred_taken) || (tk && tg != pred_target);
    @(posedge clk);
    if (rst) begin
      m_upd = 0; m_br = 0; m_red = 0; m_addr = '0; m_pc = '0; m_rpc = '0;
      m_flush_rem = 0; m_bc = 0; m_mc = 0;
    end else begin
      if (m_flush_rem > 0) m_flush_rem--;
      m_upd = acc;
      m_red = acc && mis;
      if (acc) begin
        m_br = tk; m_addr = tg; m_pc = pc;
        if (m_bc < 64'hFFFF_FFFF) m_bc++;
        if (mis) begin
          m_rpc = tk ? tg : pc + 32'd4;
          m_flush_rem = FC;
          if (m_mc < 64'hFFFF_FFFF) m_mc++;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic [2:0] t, input logic [AW-1:0] p, input logic [AW-1:0] a,
                       input logic [AW-1:0] b, input logic [AW-1:0] i, input bit pt,
                       input logic [AW-1:0] ptg);
    valid = 1; stall = 0; br_type = t; pc = p; rs1 = a; rs2 = b; imm = i;
    pred_taken = pt; pred_target = ptg;
  endtask

  task automatic idle_cycles(input int n);
    valid = 0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic test_reset();
    rst = 1; cycle(); cycle();
    checks++; if ({br_update, br, redirect, flush} !== 4'b0) begin errors++;
      $display("FAIL reset_bits got %b want 0000", {br_update, br, redirect, flush}); end
    checks++; if ({br_address, br_pc, redirect_pc} !== '0) begin errors++;
      $display("FAIL reset_buses got %h %h %h want 0", br_address, br_pc, redirect_pc); end
    rst = 0;
  endtask

  task automatic test_beq();
    drive(3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120);
    cycle(); valid = 0;
    checks++; if ({br_update, br, redirect, flush} !== 4'b1100) begin errors++;
      $display("FAIL beq_bits got %b want 1100", {br_update, br, redirect, flush}); end
    checks++; if (br_address !== 32'h120 || br_pc !== 32'h100) begin errors++;
      $display("FAIL beq_addr got %h/%h want 00000120/00000100", br_address, br_pc); end
    cycle();
    checks++; if (br_update !== 1'b0 || br_address !== 32'h120) begin errors++;
      $display("FAIL beq_hold got upd=%b addr=%h want 0/00000120", br_update, br_address); end
  endtask

  task automatic test_bne_mispredict();
    drive(3'd1, 32'h200, 32'd7, 32'd7, 32'h40, 1, 32'h240);
    cycle();
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h204 || flush !== 1'b1) begin errors++;
      $display("FAIL bne_redirect got red=%b pc=%h fl=%b want 1/00000204/1", redirect, redirect_pc, flush); end
    drive(3'd0, 32'h300, 32'd1, 32'd1, 32'h8, 1, 32'h308);
    cycle();
    checks++; if (br_update !== 1'b0 || flush !== 1'b1 || redirect !== 1'b0) begin errors++;
      $display("FAIL bne_flush2 got upd=%b fl=%b red=%b want 0/1/0", br_update, flush, redirect); end
    cycle(); valid = 0;
    checks++; if (br_update !== 1'b0 || flush !== 1'b0) begin errors++;
      $display("FAIL bne_flush_end got upd=%b fl=%b want 0/0", br_update, flush); end
  endtask

  task automatic test_jalr();
    drive(3'd7, 32'h500, 32'h1001, 32'h0, 32'h4, 1, 32'h1004);
    cycle(); valid = 0;
    checks++; if (br_address !== 32'h1004 || redirect !== 1'b0 || br !== 1'b1) begin errors++;
      $display("FAIL jalr_ok got addr=%h red=%b br=%b want 00001004/0/1", br_address, redirect, br); end
    drive(3'd7, 32'h500, 32'h1001, 32'h0, 32'h4, 1, 32'h2000);
    cycle(); valid = 0;
    checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h1004) begin errors++;
      $display("FAIL jalr_mis got red=%b pc=%h want 1/00001004", redirect, redirect_pc); end
    idle_cycles(FC);
  endtask

  task automatic test_signed_unsigned();
    drive(3'd2, 32'h600, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 32'h0);
    cycle(); valid = 0;
    checks++; if (br !== 1'b1 || redirect !== 1'b1 || redirect_pc !== 32'h610) begin errors++;
      $display("FAIL blt got br=%b red=%b pc=%h want 1/1/00000610", br, redirect, redirect_pc); end
    idle_cycles(FC);
    drive(3'd4, 32'h700, 32'hFFFF_FFFF, 32'd1, 32'h10, 0, 32'h0);
    cycle(); valid = 0;
    checks++; if (br !== 1'b0 || redirect !== 1'b0 || br_address !== 32'h710) begin errors++;
      $display("FAIL bltu got br=%b red=%b addr=%h want 0/0/00000710", br, redirect, br_address); end
  endtask

  task automatic test_stall_reset();
    drive(3'd6, 32'h800, 32'h0, 32'h0, 32'h8, 1, 32'h808);
    stall = 1;
    cycle();
    checks++; if (br_update !== 1'b0) begin errors++;
      $display("FAIL stall_pulse got %b want 0", br_update); end
    drive(3'd6, 32'h800, 32'h0, 32'h0, 32'h8, 0, 32'h0);
    cycle(); valid = 0;
    checks++; if (flush !== 1'b1) begin errors++;
      $display("FAIL stall_enter_flush got %b want 1", flush); end
    rst = 1; cycle(); rst = 0;
    checks++; if ({br_update, br, redirect, flush} !== 4'b0 || br_address !== '0 || redirect_pc !== '0) begin errors++;
      $display("FAIL midflush_reset got %b addr=%h rpc=%h want 0", {br_update, br, redirect, flush}, br_address, redirect_pc); end
    drive(3'd0, 32'h900, 32'd3, 32'd3, 32'h4, 1, 32'h904);
    cycle(); valid = 0;
    checks++; if (br_update !== 1'b1 || br_pc !== 32'h900) begin errors++;
      $display("FAIL post_reset_accept got upd=%b pc=%h want 1/00000900", br_update, br_pc); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      drive(3'd6, 32'hA00 + 32'(k * 4), 32'h0, 32'h0, 32'h40, 1, 32'hA40 + 32'(k * 4));
      cycle();
      checks++; if (br_update !== 1'b1 || br_pc !== 32'hA00 + 32'(k * 4) || flush !== 1'b0) begin errors++;
        $display("FAIL b2b_%0d got upd=%b pc=%h fl=%b", k, br_update, br_pc, flush); end
    end
    valid = 0;
  endtask

  task automatic test_random();
    bit tk;
    logic [AW-1:0] tg;
    for (int n = 0; n < 400; n++) begin
      rst   = ($urandom_range(0, 59) == 0);
      valid = $urandom_range(0, 3) != 0;
      stall = $urandom_range(0, 4) == 0;
      br_type = 3'($urandom_range(0, 7));
      pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
      rs1 = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      rs2 = $urandom_range(0, 1) ? rs1 : 32'($urandom_range(0, 3));
      imm = $urandom;
      ref_resolve(br_type, pc, rs1, rs2, imm, tk, tg);
      if ($urandom_range(0, 1) != 0) begin pred_taken = tk; pred_target = tg; end
      else begin pred_taken = $urandom_range(0, 1); pred_target = $urandom_range(0, 1) ? tg : $urandom; end
      cycle();
      checks++;
      if (br_update !== m_upd || br !== m_br || br_address !== m_addr || br_pc !== m_pc ||
          redirect !== m_red || flush !== (m_flush_rem > 0) || (m_red && redirect_pc !== m_rpc)) begin
        errors++;
        $display("FAIL random_%0d got upd=%b br=%b addr=%h pc=%h red=%b rpc=%h fl=%b want %b %b %h %h %b %h %b",
                 n, br_update, br, br_address, br_pc, redirect, redirect_pc, flush,
                 m_upd, m_br, m_addr, m_pc, m_red, m_rpc, (m_flush_rem > 0));
      end
    end
    rst = 0; idle_cycles(FC + 1);
  endtask

`ifdef BR_STATS_EN
  task automatic test_stats();
    rst = 1; cycle(); rst = 0;
    drive(3'd6, 32'h10, 32'h0, 32'h0, 32'h4, 1, 32'h14); cycle();
    drive(3'd0, 32'h20, 32'd1, 32'd1, 32'h4, 1, 32'h24); cycle();
    drive(3'd0, 32'h30, 32'd1, 32'd2, 32'h4, 1, 32'h34); cycle();
    idle_cycles(FC);
    checks++; if (br_count !== 32'd3 || mis_count !== 32'd1) begin errors++;
      $display("FAIL stats_counts got %0d/%0d want 3/1", br_count, mis_count); end
    @(negedge clk);
    dut.br_count_q  = 32'hFFFF_FFFF;
    dut.mis_count_q = 32'hFFFF_FFFF;
    m_bc = 64'hFFFF_FFFF; m_mc = 64'hFFFF_FFFF;
    drive(3'd0, 32'h40, 32'd1, 32'd2, 32'h4, 1, 32'h44);
    cycle(); valid = 0;
    checks++; if (br_count !== 32'hFFFF_FFFF || mis_count !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL stats_saturate got %h/%h want ffffffff/ffffffff", br_count, mis_count); end
    idle_cycles(FC);
  endtask
`endif

  initial begin
    rst = 1; stall = 0; valid = 0; br_type = '0; pc = '0; rs1 = '0; rs2 = '0;
    imm = '0; pred_taken = 0; pred_target = '0;
    m_flush_rem = 0; m_bc = 0; m_mc = 0;
    #1;
    test_reset();
    test_beq();
    test_bne_mispredict();
    test_jalr();
    test_signed_unsigned();
    test_stall_reset();
    test_back_to_back();
    test_random();
`ifdef BR_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
